// File: rtl/ddr_pkg.sv
// Shared DDR request-queue types: command encoding, default field widths and
// the request record carried from host to activation stage.
package ddr_pkg;

   localparam int DDR_BG_W   = 2;
   localparam int DDR_BA_W   = 2;
   localparam int DDR_ROW_W  = 16;
   localparam int DDR_COL_W  = 10;
   localparam int DDR_DATA_W = 64;

   typedef enum logic [1:0] {
      NOP = 2'b00,
      RD  = 2'b01,
      WR  = 2'b10
   } cmd_t;

   typedef struct packed {
      cmd_t                  cmd;
      logic [DDR_BG_W-1:0]   bg;
      logic [DDR_BA_W-1:0]   ba;
      logic [DDR_ROW_W-1:0]  row;
      logic [DDR_COL_W-1:0]  col;
      logic [DDR_DATA_W-1:0] wr_data;
   } req_t;

   function automatic logic cmd_legal(input logic [1:0] c);
      return (c == RD) || (c == WR);
   endfunction

endpackage

// File: rtl/ddr_sync_fifo.sv
// Single-clock FIFO with N entries (N need not be a power of two); the head
// word is presented combinationally so the consumer can load it in one edge.
module ddr_sync_fifo #(
   parameter int W = 8,
   parameter int N = 7
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(N+1)-1:0]   count
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(N+1);

   logic [W-1:0]     mem_q [N];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(N-1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(N));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ddr_req_queue.sv
// Host request buffer ahead of the DDR activation stage: FIFO plus one output
// register, with fall-through on an empty queue and refresh gating of loads.
module ddr_req_queue
   import ddr_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int BG_W   = DDR_BG_W,
   parameter int BA_W   = DDR_BA_W,
   parameter int ROW_W  = DDR_ROW_W,
   parameter int COL_W  = DDR_COL_W,
   parameter int DATA_W = DDR_DATA_W
) (
   input  logic                           CK_t,
   input  logic                           reset,
   input  logic                           host_req_valid,
   input  logic [1:0]                     host_cmd,
   input  logic [BG_W+BA_W+ROW_W+COL_W-1:0] host_addr,
   input  logic [DATA_W-1:0]              host_wr_data,
   output logic                           cmd_rdy,
   input  logic                           act_idle,
   input  logic                           ref_hold,
   output logic                           req_valid,
   output logic [1:0]                     req_cmd,
   output logic [BG_W-1:0]                req_bg,
   output logic [BA_W-1:0]                req_ba,
   output logic [ROW_W-1:0]               req_row,
   output logic [COL_W-1:0]               req_col,
   output logic [DATA_W-1:0]              req_wr_data,
   output logic [$clog2(DEPTH+1)-1:0]     q_count,
   output logic                           err_illegal
);

   localparam int ADDR_W = BG_W + BA_W + ROW_W + COL_W;
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int FIFO_N = DEPTH - 1;
   localparam int FCNT_W = $clog2(FIFO_N+1);

   typedef struct packed {
      logic [1:0]        cmd;
      logic [BG_W-1:0]   bg;
      logic [BA_W-1:0]   ba;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [DATA_W-1:0] wr_data;
   } ent_t;

   localparam int ENT_W = $bits(ent_t);

   ent_t              in_ent, head_ent;
   ent_t              out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic              legal, push, xfer, can_load, load_head, fall_thru;

   ddr_sync_fifo #(.W(ENT_W), .N(FIFO_N)) u_fifo (
      .clk   (CK_t),
      .srst  (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (in_ent),
      .rdata (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign q_count = CNT_W'(fifo_count) + CNT_W'(out_valid_q);
   // The FIFO alone holds DEPTH-1; with the output register empty (refresh
   // blocked its load) a full FIFO cannot take another entry.
   assign cmd_rdy = !reset && (q_count < CNT_W'(DEPTH)) && !(fifo_full && !out_valid_q);

   always_comb begin
      in_ent.cmd     = host_cmd;
      in_ent.col     = host_addr[COL_W-1:0];
      in_ent.row     = host_addr[COL_W +: ROW_W];
      in_ent.ba      = host_addr[COL_W+ROW_W +: BA_W];
      in_ent.bg      = host_addr[ADDR_W-1 -: BG_W];
      in_ent.wr_data = (host_cmd == RD) ? '0 : host_wr_data;

      legal     = cmd_legal(host_cmd);
      push      = host_req_valid && cmd_rdy && legal;
      xfer      = out_valid_q && act_idle;
      can_load  = !out_valid_q || xfer;
      load_head = can_load && !fifo_empty && !ref_hold;
      fall_thru = can_load && fifo_empty && push && !ref_hold;
      fifo_push = push && !fall_thru;
      fifo_pop  = load_head;
      err_d     = host_req_valid && cmd_rdy && !legal;

      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (can_load) begin
         if (load_head) begin
            out_d       = head_ent;
            out_valid_d = 1'b1;
         end else if (fall_thru) begin
            out_d       = in_ent;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CK_t) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign req_valid   = out_valid_q;
   assign req_cmd     = out_q.cmd;
   assign req_bg      = out_q.bg;
   assign req_ba      = out_q.ba;
   assign req_row     = out_q.row;
   assign req_col     = out_q.col;
   assign req_wr_data = out_q.wr_data;
   assign err_illegal = err_q;

endmodule

// File: tb/tb_ddr_req_queue.sv
// Directed plus randomized bench for ddr_req_queue against a queue-based model
// of pending requests and the single issue slot.
module tb_ddr_req_queue;

   localparam int DEPTH = 8;

   logic        CK_t = 1'b0;
   logic        reset;
   logic        host_req_valid;
   logic [1:0]  host_cmd;
   logic [29:0] host_addr;
   logic [63:0] host_wr_data;
   logic        cmd_rdy;
   logic        act_idle;
   logic        ref_hold;
   logic        req_valid;
   logic [1:0]  req_cmd;
   logic [1:0]  req_bg;
   logic [1:0]  req_ba;
   logic [15:0] req_row;
   logic [9:0]  req_col;
   logic [63:0] req_wr_data;
   logic [3:0]  q_count;
   logic        err_illegal;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [29:0] addr;
      logic [63:0] data;
   } m_t;

   m_t   mq[$];
   m_t   sr;
   logic sv   = 1'b0;
   logic serr = 1'b0;

   always #5 CK_t = ~CK_t;

   ddr_req_queue #(.DEPTH(DEPTH)) dut (
      .CK_t           (CK_t),
      .reset          (reset),
      .host_req_valid (host_req_valid),
      .host_cmd       (host_cmd),
      .host_addr      (host_addr),
      .host_wr_data   (host_wr_data),
      .cmd_rdy        (cmd_rdy),
      .act_idle       (act_idle),
      .ref_hold       (ref_hold),
      .req_valid      (req_valid),
      .req_cmd        (req_cmd),
      .req_bg         (req_bg),
      .req_ba         (req_ba),
      .req_row        (req_row),
      .req_col        (req_col),
      .req_wr_data    (req_wr_data),
      .q_count        (q_count),
      .err_illegal    (err_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check cmd_rdy, advance the model, check outputs.
   task automatic step(input logic rst, input logic v, input logic [1:0] cmd,
                       input logic [29:0] addr, input logic [63:0] d,
                       input logic idle, input logic rh);
      m_t   inc;
      logic exp_rdy, legal, pushed, used;
      int   held;
      reset = rst; host_req_valid = v; host_cmd = cmd; host_addr = addr;
      host_wr_data = d; act_idle = idle; ref_hold = rh;
      #1;
      held    = mq.size() + (sv ? 1 : 0);
      exp_rdy = !rst && (held < DEPTH) && !(mq.size() == DEPTH-1 && !sv);
      chk("cmd_rdy", 64'(cmd_rdy), 64'(exp_rdy));
      legal  = (cmd == 2'b01) || (cmd == 2'b10);
      pushed = v && exp_rdy && legal;
      inc    = '{cmd: cmd, addr: addr, data: d};
      @(posedge CK_t);
      if (rst) begin
         mq.delete();
         sv   = 1'b0;
         serr = 1'b0;
      end else begin
         serr = v && exp_rdy && !legal;
         used = 1'b0;
         if (!sv || idle) begin
            if (mq.size() > 0 && !rh) begin
               sr = mq.pop_front();
               sv = 1'b1;
            end else if (mq.size() == 0 && pushed && !rh) begin
               sr = inc;
               sv = 1'b1;
               used = 1'b1;
            end else begin
               sv = 1'b0;
            end
         end
         if (pushed && !used) mq.push_back(inc);
      end
      #1;
      chk("req_valid", 64'(req_valid), 64'(sv));
      chk("q_count", 64'(q_count), 64'(mq.size() + (sv ? 1 : 0)));
      chk("err_illegal", 64'(err_illegal), 64'(serr));
      if (sv) begin
         chk("req_cmd", 64'(req_cmd), 64'(sr.cmd));
         chk("req_col", 64'(req_col), 64'(sr.addr) % 1024);
         chk("req_row", 64'(req_row), (64'(sr.addr) >> 10) % 65536);
         chk("req_ba", 64'(req_ba), (64'(sr.addr) >> 26) % 4);
         chk("req_bg", 64'(req_bg), 64'(sr.addr) >> 28);
         chk("req_wr_data", req_wr_data, (sr.cmd == 2'b01) ? 64'd0 : sr.data);
      end
      @(negedge CK_t);
   endtask

   task automatic idle_step(input logic idle, input logic rh);
      step(1'b0, 1'b0, 2'b00, 30'd0, 64'd0, idle, rh);
   endtask

   initial begin
      reset = 1'b1; host_req_valid = 1'b0; host_cmd = 2'b00; host_addr = '0;
      host_wr_data = '0; act_idle = 1'b0; ref_hold = 1'b0;

      // Reset three cycles, then idle: everything zero, ready to accept.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 30'd0, 64'd0, 1'b0, 1'b0);
      idle_step(1'b0, 1'b0);
      chk("rst_cmd", 64'(req_cmd), 64'd0);
      chk("rst_row", 64'(req_row), 64'd0);
      chk("rst_data", req_wr_data, 64'd0);

      // Single write with the activation stage idle.
      step(1'b0, 1'b1, 2'b10, 30'h2ABC_D123, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
      chk("wr_bg_fixed", 64'(req_bg), 64'd2);
      idle_step(1'b1, 1'b0);

      // Fill with reads while stalled; ninth request refused; then drain.
      for (int i = 0; i < 9; i++)
         step(1'b0, 1'b1, 2'b01, 30'(i * 30'h0123_4567 + 1), 64'(i + 100), 1'b0, 1'b0);
      chk("q_count_full", 64'(q_count), 64'd8);
      for (int i = 0; i < 9; i++) idle_step(1'b1, 1'b0);

      // Refresh hold with one in the output register and three queued.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 2'b10, 30'($urandom()), {$urandom(), $urandom()}, 1'b0, 1'b0);
      idle_step(1'b0, 1'b1);
      idle_step(1'b0, 1'b1);
      idle_step(1'b1, 1'b1);
      idle_step(1'b1, 1'b1);
      idle_step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) idle_step(1'b1, 1'b0);

      // Illegal command pulse.
      step(1'b0, 1'b1, 2'b11, 30'h1, 64'h1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 2'b00, 30'h2, 64'h2, 1'b1, 1'b0);
      idle_step(1'b1, 1'b0);

      // Reset with a full issue slot and five queued flushes everything.
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b1, 2'b01, 30'($urandom()), 64'd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2'b00, 30'd0, 64'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) idle_step(1'b1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom()), 30'($urandom()), {$urandom(), $urandom()},
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
